// File: rtl/robot_ctrl_pkg.sv
// Shared types for the robot scan scheduler: FSM state and sweep direction.
package robot_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SWEEP_L = 3'd1,
        SWEEP_R = 3'd2,
        LOCKED  = 3'd3,
        FAIL    = 3'd4
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // After losing the target, search the side it was not found on.
    function automatic state_e opposite_sweep(dir_e d);
        return (d == DIR_RIGHT) ? SWEEP_L : SWEEP_R;
    endfunction

endpackage

// File: rtl/proximity_debouncer.sv
// Two-flop synchroniser plus run-length debouncer for the raw proximity input.
module proximity_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic z,
    output logic z_db
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; flip on the last one of the run.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Synchroniser chain and debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= z;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign z_db = db_q;

endmodule

// File: rtl/robot_scan_scheduler.sv
// Search / lock / re-acquire sequencer driving the rotation motor.
module robot_scan_scheduler
    import robot_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SWEEP_CYCLES    = 16,
    parameter int LOST_TIMEOUT    = 8,
    parameter int MAX_SWEEPS      = 6,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             z,
    input  logic             motor_ready,
    output logic             left,
    output logic             right,
    output logic             locked,
    output logic             search_fail,
    output logic [CNT_W-1:0] sweep_count
);

    localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(SWEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOST_LAST  = CNT_W'(LOST_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SWEEP_MAX  = CNT_W'(MAX_SWEEPS);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic             z_db;
    state_e           state_q, state_d;
    dir_e             last_dir_q, last_dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] lost_q, lost_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             left_q, right_q, locked_q, fail_q;

    proximity_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .z    (z),
        .z_db (z_db)
    );

    assign count_inc = count_q + ONE;

    // Next-state logic; en=0 overrides everything and every state change clears the timers.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        timer_d    = timer_q;
        lost_d     = lost_q;
        count_d    = count_q;
        if (!en) begin
            state_d = IDLE;
            timer_d = '0;
            lost_d  = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SWEEP_L;
                    timer_d = '0;
                    lost_d  = '0;
                    count_d = '0;
                end
                SWEEP_L, SWEEP_R: begin
                    if (z_db) begin
                        // Target seen: lock takes precedence over a sweep expiring this cycle.
                        state_d    = LOCKED;
                        timer_d    = '0;
                        lost_d     = '0;
                        last_dir_d = (state_q == SWEEP_L) ? DIR_LEFT : DIR_RIGHT;
                    end else if (motor_ready) begin
                        if (timer_q == SWEEP_LAST) begin
                            timer_d = '0;
                            count_d = count_inc;
                            if (count_inc == SWEEP_MAX) begin
                                state_d = FAIL;
                            end else begin
                                state_d = (state_q == SWEEP_L) ? SWEEP_R : SWEEP_L;
                            end
                        end else begin
                            timer_d = timer_q + ONE;
                        end
                    end
                end
                LOCKED: begin
                    if (z_db) begin
                        lost_d = '0;
                    end else if (lost_q == LOST_LAST) begin
                        state_d = opposite_sweep(last_dir_q);
                        lost_d  = '0;
                        timer_d = '0;
                        count_d = '0;
                    end else begin
                        lost_d = lost_q + ONE;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and outputs decoded from the next state so they align with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_dir_q <= DIR_LEFT;
            timer_q    <= '0;
            lost_q     <= '0;
            count_q    <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            timer_q    <= timer_d;
            lost_q     <= lost_d;
            count_q    <= count_d;
            left_q     <= (state_d == SWEEP_L);
            right_q    <= (state_d == SWEEP_R);
            locked_q   <= (state_d == LOCKED);
            fail_q     <= (state_d == FAIL);
        end
    end

    assign left        = left_q;
    assign right       = right_q;
    assign locked      = locked_q;
    assign search_fail = fail_q;
    assign sweep_count = count_q;

endmodule
